// File: rtl/code_loader.sv
// code_loader: boot-time program loader. Frames the UART byte stream into
// 32-bit words, writes them to code_memory and checks an additive checksum.
module code_loader #(
  parameter int CODE_SIZE = 32767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  // Number of words code_memory can hold; a longer frame is rejected up front.
  localparam logic [31:0] MAX_WORDS = 32'(CODE_SIZE) + 32'd1;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] len_q, len_d;
  logic [31:0] asm_q, asm_d;
  logic [7:0]  sum_q, sum_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  // Completed values as they look on the cycle their last byte arrives.
  logic [31:0] full_len;
  logic [31:0] full_word;
  assign full_len  = {rx_data, len_q[23:0]};
  assign full_word = {rx_data, asm_q[23:0]};

  // Next-state and datapath updates; every register holds unless a byte or start arrives.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    len_d       = len_q;
    asm_d       = asm_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN;
          done_d     = 1'b0;
          error_d    = 1'b0;
          byte_cnt_d = 2'd0;
          word_cnt_d = 32'd0;
          len_d      = 32'd0;
          asm_d      = 32'd0;
          sum_d      = 8'd0;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          len_d[8*byte_cnt_q +: 8] = rx_data;
          byte_cnt_d               = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (full_len == 32'd0) begin
              state_d = S_CSUM;
            end else if (full_len > MAX_WORDS) begin
              state_d = S_ERROR;
              error_d = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          asm_d[8*byte_cnt_q +: 8] = rx_data;
          sum_d                    = sum_q + rx_data;
          byte_cnt_d               = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_cnt_q;
            mem_wdata_d = full_word;
            word_cnt_d  = word_cnt_q + 32'd1;
            if (word_cnt_q == len_q - 32'd1) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == sum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any partial load at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= 2'd0;
      word_cnt_q  <= 32'd0;
      len_q       <= 32'd0;
      asm_q       <= 32'd0;
      sum_q       <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      asm_q       <= asm_d;
      sum_q       <= sum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign busy      = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_code_loader.sv
// tb_code_loader: randomized self-checking bench for code_loader. A small
// instance (CODE_SIZE=15) carries most frames; a default-size instance
// checks the 32768-word length boundary.
module tb_code_loader;

  localparam int          SMALL_SIZE = 15;
  localparam logic [31:0] SMALL_MAX  = 32'd16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, rx_valid;
  logic [7:0]  rx_data;
  logic        mem_we, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;

  logic        start_b, rx_valid_b;
  logic [7:0]  rx_data_b;
  logic        mem_we_b, busy_b, done_b, error_b;
  logic [31:0] mem_addr_b, mem_wdata_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int big_we_cnt = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [31:0] frame_words[$];

  code_loader #(.CODE_SIZE(SMALL_SIZE)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error)
  );

  code_loader big (
    .clk(clk), .rst(rst), .start(start_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .busy(busy_b), .done(done_b), .error(error_b)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp memory writes.
  always @(posedge clk) cyc = cyc + 1;

  // Record every write seen by code_memory, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (mem_we_b !== 1'b0) big_we_cnt = big_we_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Send one byte (optionally with start in the same cycle); called at posedge+1.
  task automatic applyStimulus(input logic [7:0] b, input bit b2b, input bit with_start);
    if (!b2b) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    start    = with_start;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    start    = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulseStart(input bit with_byte);
    start    = 1'b1;
    rx_valid = with_byte;
    rx_data  = 8'($urandom);
    @(posedge clk); #1;
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  // Load frame_words with length n_len; reference result derived from the frame rules.
  task automatic runFrame(input string tag, input logic [31:0] n_len, input bit b2b,
                          input logic [7:0] csum_xor, input bit inject_start,
                          input bit start_with_byte);
    logic [7:0]  sum;
    logic [31:0] w;
    logic [7:0]  b;
    bit          overflow;
    bit          exp_err;
    int          exp_writes;
    sum      = 8'd0;
    overflow = (n_len > SMALL_MAX);
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    pulseStart(start_with_byte);
    for (int i = 0; i < 4; i++) applyStimulus(8'(n_len >> (8 * i)), b2b, 1'b0);
    if (overflow) begin
      checkOutput({tag, ".err_now"}, {31'd0, error}, 32'd1);
    end else begin
      for (int k = 0; k < frame_words.size(); k++) begin
        w = frame_words[k];
        for (int j = 0; j < 4; j++) begin
          b   = 8'(w >> (8 * j));
          sum = sum + b;
          applyStimulus(b, b2b, inject_start && (k == 1) && (j == 1));
        end
      end
      applyStimulus(sum ^ csum_xor, b2b, 1'b0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_err    = overflow || (csum_xor != 8'd0);
    exp_writes = overflow ? 0 : int'(n_len);
    checkOutput({tag, ".nwrites"}, wr_addr_q.size(), exp_writes);
    for (int k = 0; k < exp_writes && k < wr_addr_q.size(); k++) begin
      checkOutput($sformatf("%s.addr%0d", tag, k), wr_addr_q[k], k);
      checkOutput($sformatf("%s.data%0d", tag, k), wr_data_q[k], frame_words[k]);
      if (b2b && k > 0)
        checkOutput($sformatf("%s.gap%0d", tag, k), wr_cyc_q[k] - wr_cyc_q[k-1], 4);
    end
    checkOutput({tag, ".done"},  {31'd0, done},  {31'd0, !exp_err});
    checkOutput({tag, ".error"}, {31'd0, error}, {31'd0, exp_err});
    checkOutput({tag, ".busy"},  {31'd0, busy},  32'd0);
    @(posedge clk); #1;
  endtask

  task automatic bigByte(input logic [7:0] b);
    rx_valid_b = 1'b1;
    rx_data_b  = b;
    @(posedge clk); #1;
    rx_valid_b = 1'b0;
  endtask

  initial begin
    logic [31:0] n;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    start_b = 1'b0; rx_valid_b = 1'b0; rx_data_b = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.mem_we",    {31'd0, mem_we}, 32'd0);
    checkOutput("rst.mem_addr",  mem_addr,        32'd0);
    checkOutput("rst.mem_wdata", mem_wdata,       32'd0);
    checkOutput("rst.busy",      {31'd0, busy},   32'd0);
    checkOutput("rst.done",      {31'd0, done},   32'd0);
    checkOutput("rst.error",     {31'd0, error},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    frame_words = '{32'h12345678, 32'hDEADBEEF};
    runFrame("t1", 32'd2, 1'b0, 8'h00, 1'b0, 1'b0);
    runFrame("t2", 32'd2, 1'b0, 8'h01, 1'b0, 1'b0);

    frame_words.delete();
    runFrame("t4ok",  32'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    runFrame("t4bad", 32'd0, 1'b0, 8'h01, 1'b0, 1'b0);

    frame_words.delete();
    for (int k = 0; k < 16; k++) frame_words.push_back($urandom);
    runFrame("t3max", 32'd16, 1'b1, 8'h00, 1'b0, 1'b0);
    frame_words.delete();
    runFrame("t3ovf", 32'd17, 1'b0, 8'h00, 1'b0, 1'b0);

    frame_words.delete();
    for (int k = 0; k < 3; k++) frame_words.push_back($urandom);
    runFrame("t5", 32'd3, 1'b1, 8'h00, 1'b0, 1'b0);

    frame_words = '{32'h0BADF00D, 32'hCAFEBABE};
    runFrame("tsw", 32'd2, 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset in the middle of a load, then a clean reload with a stray start.
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    pulseStart(1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0);
    repeat (3) applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    applyStimulus(8'h33, 1'b1, 1'b0);
    applyStimulus(8'h44, 1'b1, 1'b0);
    applyStimulus(8'h55, 1'b1, 1'b0);
    applyStimulus(8'h66, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t6.part_n",    wr_addr_q.size(), 32'd1);
    checkOutput("t6.part_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hFFFFFFFF, 32'h44332211);
    rst = 1'b1;
    #2;
    checkOutput("t6.rst_we",   {31'd0, mem_we}, 32'd0);
    checkOutput("t6.rst_busy", {31'd0, busy},   32'd0);
    checkOutput("t6.rst_addr", mem_addr,        32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    frame_words = '{32'h12345678, 32'hDEADBEEF};
    runFrame("t6", 32'd2, 1'b0, 8'h00, 1'b1, 1'b0);

    // Random frames with stray idle bytes, corrupt checksums and spurious starts.
    for (int it = 0; it < 20; it++) begin
      n = 32'($urandom_range(1, 8));
      frame_words.delete();
      for (int k = 0; k < int'(n); k++) frame_words.push_back($urandom);
      repeat ($urandom_range(0, 2)) applyStimulus(8'($urandom), 1'b0, 1'b0);
      runFrame($sformatf("rnd%0d", it), n, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Full-size instance: 32768 words accepted, 32769 rejected without writes.
    start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
    bigByte(8'h00); bigByte(8'h80); bigByte(8'h00); bigByte(8'h00);
    @(negedge clk);
    checkOutput("big.max_busy",  {31'd0, busy_b},  32'd1);
    checkOutput("big.max_error", {31'd0, error_b}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    big_we_cnt = 0;
    start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
    bigByte(8'h01); bigByte(8'h80); bigByte(8'h00); bigByte(8'h00);
    @(negedge clk);
    checkOutput("big.ovf_error", {31'd0, error_b}, 32'd1);
    checkOutput("big.ovf_busy",  {31'd0, busy_b},  32'd0);
    checkOutput("big.ovf_done",  {31'd0, done_b},  32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("big.ovf_writes", big_we_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
